// File: rtl/rvfi_pack_pkg.sv
// Record type and sizing helpers shared by the RVFI pack buffer.
// RVFI_PACK_MEM_EN adds the mem_* fields to every buffered record.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif

package rvfi_pack_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int MASK_W = XLEN / 8;
  localparam int NRET_DEFAULT = `RISCV_FORMAL_NRET;

  typedef struct packed {
    logic [ILEN-1:0]   insn;
    logic              trap;
    logic              halt;
    logic              intr;
    logic [1:0]        mode;
    logic [1:0]        ixl;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_rdata;
    logic [XLEN-1:0]   pc_wdata;
`ifdef RVFI_PACK_MEM_EN
    logic [XLEN-1:0]   mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
`endif
  } rvfi_rec_t;

  localparam int REC_W = $bits(rvfi_rec_t);

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rvfi_pack_fifo.sv
// Record FIFO: one push per cycle, up to NRET pops, oldest NRET entries visible at the head.
module rvfi_pack_fifo
  import rvfi_pack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NRET  = 1,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = ptr_w(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  rvfi_rec_t     wr_rec,
  input  logic [CW-1:0] pop_n,
  output logic [CW-1:0] count,
  output rvfi_rec_t     head [NRET]
);
  rvfi_rec_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= wr_rec;
  end

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_n);
      count_reg  <= count_reg + CW'(push) - pop_n;
    end
  end

  assign count = count_reg;

  for (genvar gi = 0; gi < NRET; gi++) begin : g_head
    assign head[gi] = mem[rd_ptr_reg + PW'(gi)];
  end
endmodule

// File: rtl/rvfi_pack_buffer.sv
// Buffers retirement records, numbers them with a 64-bit order and packs up to NRET per cycle
// onto the registered rvfi_* bus. Optional mem_* fields are controlled by RVFI_PACK_MEM_EN.
module rvfi_pack_buffer
  import rvfi_pack_pkg::*;
#(
  parameter int NRET  = NRET_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ILEN-1:0]          in_insn,
  input  logic                     in_trap,
  input  logic                     in_halt,
  input  logic                     in_intr,
  input  logic [1:0]               in_mode,
  input  logic [1:0]               in_ixl,
  input  logic [4:0]               in_rs1_addr,
  input  logic [4:0]               in_rs2_addr,
  input  logic [4:0]               in_rd_addr,
  input  logic [XLEN-1:0]          in_rs1_rdata,
  input  logic [XLEN-1:0]          in_rs2_rdata,
  input  logic [XLEN-1:0]          in_rd_wdata,
  input  logic [XLEN-1:0]          in_pc_rdata,
  input  logic [XLEN-1:0]          in_pc_wdata,
  input  logic [XLEN-1:0]          in_mem_addr,
  input  logic [MASK_W-1:0]        in_mem_rmask,
  input  logic [MASK_W-1:0]        in_mem_wmask,
  input  logic [XLEN-1:0]          in_mem_rdata,
  input  logic [XLEN-1:0]          in_mem_wdata,
  input  logic                     emit_en,
  output logic [NRET-1:0]          rvfi_valid,
  output logic [NRET*64-1:0]       rvfi_order,
  output logic [NRET*ILEN-1:0]     rvfi_insn,
  output logic [NRET-1:0]          rvfi_trap,
  output logic [NRET-1:0]          rvfi_halt,
  output logic [NRET-1:0]          rvfi_intr,
  output logic [NRET*2-1:0]        rvfi_mode,
  output logic [NRET*2-1:0]        rvfi_ixl,
  output logic [NRET*5-1:0]        rvfi_rs1_addr,
  output logic [NRET*5-1:0]        rvfi_rs2_addr,
  output logic [NRET*XLEN-1:0]     rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0]     rvfi_rs2_rdata,
  output logic [NRET*5-1:0]        rvfi_rd_addr,
  output logic [NRET*XLEN-1:0]     rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0]     rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0]     rvfi_mem_addr,
  output logic [NRET*MASK_W-1:0]   rvfi_mem_rmask,
  output logic [NRET*MASK_W-1:0]   rvfi_mem_wmask,
  output logic [NRET*XLEN-1:0]     rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0]     rvfi_mem_wdata
);
  localparam int CW = ptr_w(DEPTH + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] pop_n;
  logic          push;
  logic          halted_reg;
  logic [63:0]   ord_base_reg;
  rvfi_rec_t     in_rec;
  rvfi_rec_t     head [NRET];

  assign in_ready = resetn && !halted_reg && (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    in_rec           = '0;
    in_rec.insn      = in_insn;
    in_rec.trap      = in_trap;
    in_rec.halt      = in_halt;
    in_rec.intr      = in_intr;
    in_rec.mode      = in_mode;
    in_rec.ixl       = in_ixl;
    in_rec.rs1_addr  = in_rs1_addr;
    in_rec.rs2_addr  = in_rs2_addr;
    in_rec.rd_addr   = in_rd_addr;
    in_rec.rs1_rdata = in_rs1_rdata;
    in_rec.rs2_rdata = in_rs2_rdata;
    in_rec.rd_wdata  = in_rd_wdata;
    in_rec.pc_rdata  = in_pc_rdata;
    in_rec.pc_wdata  = in_pc_wdata;
`ifdef RVFI_PACK_MEM_EN
    in_rec.mem_addr  = in_mem_addr;
    in_rec.mem_rmask = in_mem_rmask;
    in_rec.mem_wmask = in_mem_wmask;
    in_rec.mem_rdata = in_mem_rdata;
    in_rec.mem_wdata = in_mem_wdata;
`endif
  end

  // Pop count uses the occupancy before this edge's push, so a record never bypasses the FIFO.
  always_comb begin
    pop_n = '0;
    if (emit_en) pop_n = (count < CW'(NRET)) ? count : CW'(NRET);
  end

  rvfi_pack_fifo #(
    .DEPTH (DEPTH),
    .NRET  (NRET)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .wr_rec (in_rec),
    .pop_n  (pop_n),
    .count  (count),
    .head   (head)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      halted_reg   <= 1'b0;
      ord_base_reg <= '0;
    end else begin
      if (push && in_halt) halted_reg <= 1'b1;
      ord_base_reg <= ord_base_reg + 64'(pop_n);
    end
  end

  for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
    logic        ch_valid_reg;
    logic [63:0] ch_order_reg;
    rvfi_rec_t   ch_rec_reg;

    // Idle channels are cleared to zero rather than holding stale data.
    always_ff @(posedge clock) begin
      if (!resetn || (CW'(gi) >= pop_n)) begin
        ch_valid_reg <= 1'b0;
        ch_order_reg <= '0;
        ch_rec_reg   <= '0;
      end else begin
        ch_valid_reg <= 1'b1;
        ch_order_reg <= ord_base_reg + 64'(gi);
        ch_rec_reg   <= head[gi];
      end
    end

    assign rvfi_valid[gi]                  = ch_valid_reg;
    assign rvfi_order[gi*64 +: 64]         = ch_order_reg;
    assign rvfi_insn[gi*ILEN +: ILEN]      = ch_rec_reg.insn;
    assign rvfi_trap[gi]                   = ch_rec_reg.trap;
    assign rvfi_halt[gi]                   = ch_rec_reg.halt;
    assign rvfi_intr[gi]                   = ch_rec_reg.intr;
    assign rvfi_mode[gi*2 +: 2]            = ch_rec_reg.mode;
    assign rvfi_ixl[gi*2 +: 2]             = ch_rec_reg.ixl;
    assign rvfi_rs1_addr[gi*5 +: 5]        = ch_rec_reg.rs1_addr;
    assign rvfi_rs2_addr[gi*5 +: 5]        = ch_rec_reg.rs2_addr;
    assign rvfi_rd_addr[gi*5 +: 5]         = ch_rec_reg.rd_addr;
    assign rvfi_rs1_rdata[gi*XLEN +: XLEN] = ch_rec_reg.rs1_rdata;
    assign rvfi_rs2_rdata[gi*XLEN +: XLEN] = ch_rec_reg.rs2_rdata;
    assign rvfi_rd_wdata[gi*XLEN +: XLEN]  = ch_rec_reg.rd_wdata;
    assign rvfi_pc_rdata[gi*XLEN +: XLEN]  = ch_rec_reg.pc_rdata;
    assign rvfi_pc_wdata[gi*XLEN +: XLEN]  = ch_rec_reg.pc_wdata;
`ifdef RVFI_PACK_MEM_EN
    assign rvfi_mem_addr[gi*XLEN +: XLEN]     = ch_rec_reg.mem_addr;
    assign rvfi_mem_rmask[gi*MASK_W +: MASK_W] = ch_rec_reg.mem_rmask;
    assign rvfi_mem_wmask[gi*MASK_W +: MASK_W] = ch_rec_reg.mem_wmask;
    assign rvfi_mem_rdata[gi*XLEN +: XLEN]    = ch_rec_reg.mem_rdata;
    assign rvfi_mem_wdata[gi*XLEN +: XLEN]    = ch_rec_reg.mem_wdata;
`endif
  end

`ifdef RVFI_PACK_MEM_EN
`else
  logic unused_mem;
  assign unused_mem     = ^{in_mem_addr, in_mem_rmask, in_mem_wmask, in_mem_rdata, in_mem_wdata};
  assign rvfi_mem_addr  = '0;
  assign rvfi_mem_rmask = '0;
  assign rvfi_mem_wmask = '0;
  assign rvfi_mem_rdata = '0;
  assign rvfi_mem_wdata = '0;
`endif
endmodule

// File: tb/tb_rvfi_pack_buffer.sv
// Directed bench for rvfi_pack_buffer: one NRET=1 instance and one NRET=2 instance, DEPTH=8.
module tb_rvfi_pack_buffer;
  import rvfi_pack_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn;
  logic in_valid1, in_valid2, emit_en1, emit_en2;
  logic in_ready1, in_ready2;
  logic [31:0] in_insn;
  logic in_trap, in_halt, in_intr;
  logic [1:0] in_mode, in_ixl;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_rdata, in_rs2_rdata, in_rd_wdata, in_pc_rdata, in_pc_wdata;
  logic [31:0] in_mem_addr, in_mem_rdata, in_mem_wdata;
  logic [3:0] in_mem_rmask, in_mem_wmask;

  logic [0:0] d1_valid, d1_trap, d1_halt, d1_intr;
  logic [63:0] d1_order;
  logic [31:0] d1_insn, d1_rs1_rdata, d1_rs2_rdata, d1_rd_wdata, d1_pc_rdata, d1_pc_wdata;
  logic [31:0] d1_mem_addr, d1_mem_rdata, d1_mem_wdata;
  logic [1:0] d1_mode, d1_ixl;
  logic [4:0] d1_rs1_addr, d1_rs2_addr, d1_rd_addr;
  logic [3:0] d1_mem_rmask, d1_mem_wmask;

  logic [1:0] d2_valid, d2_trap, d2_halt, d2_intr;
  logic [127:0] d2_order;
  logic [63:0] d2_insn, d2_rs1_rdata, d2_rs2_rdata, d2_rd_wdata, d2_pc_rdata, d2_pc_wdata;
  logic [63:0] d2_mem_addr, d2_mem_rdata, d2_mem_wdata;
  logic [3:0] d2_mode, d2_ixl;
  logic [9:0] d2_rs1_addr, d2_rs2_addr, d2_rd_addr;
  logic [7:0] d2_mem_rmask, d2_mem_wmask;

  int checks = 0;
  int errors = 0;

  rvfi_pack_buffer #(.NRET(1), .DEPTH(8)) dut1 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_insn(in_insn), .in_trap(in_trap), .in_halt(in_halt), .in_intr(in_intr),
    .in_mode(in_mode), .in_ixl(in_ixl), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata),
    .in_rd_wdata(in_rd_wdata), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_mem_addr(in_mem_addr), .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
    .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata), .emit_en(emit_en1),
    .rvfi_valid(d1_valid), .rvfi_order(d1_order), .rvfi_insn(d1_insn), .rvfi_trap(d1_trap),
    .rvfi_halt(d1_halt), .rvfi_intr(d1_intr), .rvfi_mode(d1_mode), .rvfi_ixl(d1_ixl),
    .rvfi_rs1_addr(d1_rs1_addr), .rvfi_rs2_addr(d1_rs2_addr), .rvfi_rs1_rdata(d1_rs1_rdata),
    .rvfi_rs2_rdata(d1_rs2_rdata), .rvfi_rd_addr(d1_rd_addr), .rvfi_rd_wdata(d1_rd_wdata),
    .rvfi_pc_rdata(d1_pc_rdata), .rvfi_pc_wdata(d1_pc_wdata), .rvfi_mem_addr(d1_mem_addr),
    .rvfi_mem_rmask(d1_mem_rmask), .rvfi_mem_wmask(d1_mem_wmask),
    .rvfi_mem_rdata(d1_mem_rdata), .rvfi_mem_wdata(d1_mem_wdata)
  );

  rvfi_pack_buffer #(.NRET(2), .DEPTH(8)) dut2 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_insn(in_insn), .in_trap(in_trap), .in_halt(in_halt), .in_intr(in_intr),
    .in_mode(in_mode), .in_ixl(in_ixl), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata),
    .in_rd_wdata(in_rd_wdata), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_mem_addr(in_mem_addr), .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
    .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata), .emit_en(emit_en2),
    .rvfi_valid(d2_valid), .rvfi_order(d2_order), .rvfi_insn(d2_insn), .rvfi_trap(d2_trap),
    .rvfi_halt(d2_halt), .rvfi_intr(d2_intr), .rvfi_mode(d2_mode), .rvfi_ixl(d2_ixl),
    .rvfi_rs1_addr(d2_rs1_addr), .rvfi_rs2_addr(d2_rs2_addr), .rvfi_rs1_rdata(d2_rs1_rdata),
    .rvfi_rs2_rdata(d2_rs2_rdata), .rvfi_rd_addr(d2_rd_addr), .rvfi_rd_wdata(d2_rd_wdata),
    .rvfi_pc_rdata(d2_pc_rdata), .rvfi_pc_wdata(d2_pc_wdata), .rvfi_mem_addr(d2_mem_addr),
    .rvfi_mem_rmask(d2_mem_rmask), .rvfi_mem_wmask(d2_mem_wmask),
    .rvfi_mem_rdata(d2_mem_rdata), .rvfi_mem_wdata(d2_mem_wdata)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rec(input logic [31:0] pc, input logic [31:0] insn, input logic halt);
    in_pc_rdata = pc;
    in_pc_wdata = pc + 32'd4;
    in_insn     = insn;
    in_halt     = halt;
    in_rd_addr  = pc[6:2];
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid1 = 1'b0; in_valid2 = 1'b0; emit_en1 = 1'b0; emit_en2 = 1'b0;
    in_trap = 1'b0; in_intr = 1'b0; in_mode = 2'd3; in_ixl = 2'd1;
    in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
    in_rs1_rdata = 32'h11; in_rs2_rdata = 32'h22; in_rd_wdata = 32'h33;
    in_mem_addr = 32'h8000_0000; in_mem_rdata = 32'hA5A5_A5A5; in_mem_wdata = 32'h5A5A_5A5A;
    in_mem_rmask = 4'h0; in_mem_wmask = 4'hF;
    set_rec(32'h0, 32'h0, 1'b0);
    tick(); tick();
    $display("reset: in_ready=%b/%b valid=%b/%b", in_ready1, in_ready2, d1_valid, d2_valid);
    checks++; if (in_ready1 !== 1'b0 || in_ready2 !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b%b exp=00", in_ready1, in_ready2);
    end
    checks++; if (d1_valid !== 1'b0 || d2_valid !== 2'b00) begin
      errors++; $display("FAIL reset_valid got=%b %b exp=0 00", d1_valid, d2_valid);
    end
    checks++; if (d2_order !== 128'd0 || d2_insn !== 64'd0 || d1_order !== 64'd0) begin
      errors++; $display("FAIL reset_fields order2=%h insn2=%h exp=0", d2_order, d2_insn);
    end
    resetn = 1'b1;
    tick();
    checks++; if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got=%b%b exp=11", in_ready1, in_ready2);
    end
  endtask

  task automatic test_single_channel();
    logic [3:0] exp_wmask;
`ifdef RVFI_PACK_MEM_EN
    exp_wmask = 4'hF;
`else
    exp_wmask = 4'h0;
`endif
    emit_en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid1 = 1'b1;
        set_rec(32'h1000 + 32'(4 * i), 32'h0000_0013, 1'b0);
      end else begin
        in_valid1 = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 3) begin
        $display("nret1 cyc %0d: valid=%b order=%0d pc=%h insn=%h wmask=%h",
                 i, d1_valid, d1_order, d1_pc_rdata, d1_insn, d1_mem_wmask);
        checks++; if (d1_valid !== 1'b1 || d1_order !== 64'(i - 1)) begin
          errors++; $display("FAIL nret1_order got=%b/%0d exp=1/%0d", d1_valid, d1_order, i - 1);
        end
        checks++; if (d1_pc_rdata !== 32'h1000 + 32'(4 * (i - 1)) || d1_insn !== 32'h13) begin
          errors++; $display("FAIL nret1_data got pc=%h insn=%h", d1_pc_rdata, d1_insn);
        end
        checks++; if (d1_mem_wmask !== exp_wmask) begin
          errors++; $display("FAIL nret1_mem_wmask got=%h exp=%h", d1_mem_wmask, exp_wmask);
        end
      end else if (i == 4) begin
        checks++; if (d1_valid !== 1'b0) begin
          errors++; $display("FAIL nret1_idle got=%b exp=0", d1_valid);
        end
      end
    end
    emit_en1 = 1'b0;
  endtask

  task automatic test_dual_channel();
    emit_en2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1;
      set_rec(32'h2000 + 32'(4 * i), 32'h13 | 32'(i << 7), 1'b0);
      tick();
    end
    in_valid2 = 1'b0;
    checks++; if (d2_valid !== 2'b00) begin
      errors++; $display("FAIL nret2_hold got=%b exp=00", d2_valid);
    end
    emit_en2 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      $display("nret2 cyc %0d: valid=%b order=%0d,%0d pc=%h,%h", c, d2_valid,
               d2_order[63:0], d2_order[127:64], d2_pc_rdata[31:0], d2_pc_rdata[63:32]);
      checks++; if (d2_valid !== 2'b11 || d2_order[63:0] !== 64'(2 * c)
                    || d2_order[127:64] !== 64'(2 * c + 1)) begin
        errors++; $display("FAIL nret2_pair got=%b %0d,%0d exp=11 %0d,%0d", d2_valid,
                           d2_order[63:0], d2_order[127:64], 2 * c, 2 * c + 1);
      end
      checks++; if (d2_pc_rdata[31:0] !== 32'h2000 + 32'(8 * c)
                    || d2_pc_rdata[63:32] !== 32'h2004 + 32'(8 * c)
                    || d2_insn[63:32] !== (32'h13 | 32'((2 * c + 1) << 7))) begin
        errors++; $display("FAIL nret2_pair_data got pc=%h insn=%h", d2_pc_rdata, d2_insn);
      end
    end
    tick();
    $display("nret2 cyc 2: valid=%b order=%0d pc=%h", d2_valid, d2_order[63:0], d2_pc_rdata[31:0]);
    checks++; if (d2_valid !== 2'b01 || d2_order[63:0] !== 64'd4 || d2_pc_rdata[31:0] !== 32'h2010) begin
      errors++; $display("FAIL nret2_tail got=%b %0d %h exp=01 4 2010",
                         d2_valid, d2_order[63:0], d2_pc_rdata[31:0]);
    end
    checks++; if (d2_order[127:64] !== 64'd0 || d2_insn[63:32] !== 32'd0
                  || d2_pc_rdata[63:32] !== 32'd0 || d2_pc_wdata[63:32] !== 32'd0) begin
      errors++; $display("FAIL nret2_idle_ch1 got order=%h insn=%h pc=%h exp=0",
                         d2_order[127:64], d2_insn[63:32], d2_pc_rdata[63:32]);
    end
    tick();
    checks++; if (d2_valid !== 2'b00) begin
      errors++; $display("FAIL nret2_drained got=%b exp=00", d2_valid);
    end
    emit_en2 = 1'b0;
  endtask

  task automatic test_full();
    // Order base continues at 5 from the previous scenario.
    emit_en2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_ready2 !== 1'b1) begin
        errors++; $display("FAIL full_ready_%0d got=0 exp=1", i);
      end
      in_valid2 = 1'b1;
      set_rec(32'h3000 + 32'(4 * i), 32'h13, 1'b0);
      tick();
    end
    checks++; if (in_ready2 !== 1'b0) begin
      errors++; $display("FAIL full_ready_low got=1 exp=0");
    end
    set_rec(32'h3FF0, 32'h13, 1'b0);
    tick();
    in_valid2 = 1'b0;
    $display("full: 9th offer ready=%b", in_ready2);
    emit_en2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      $display("full drain %0d: valid=%b order=%0d,%0d pc=%h,%h", c, d2_valid,
               d2_order[63:0], d2_order[127:64], d2_pc_rdata[31:0], d2_pc_rdata[63:32]);
      checks++; if (d2_valid !== 2'b11 || d2_order[63:0] !== 64'(5 + 2 * c)
                    || d2_order[127:64] !== 64'(6 + 2 * c)
                    || d2_pc_rdata[31:0] !== 32'h3000 + 32'(8 * c)
                    || d2_pc_rdata[63:32] !== 32'h3004 + 32'(8 * c)) begin
        errors++; $display("FAIL full_drain_%0d got=%b %0d,%0d %h", c, d2_valid,
                           d2_order[63:0], d2_order[127:64], d2_pc_rdata);
      end
      if (c == 0) begin
        checks++; if (in_ready2 !== 1'b1) begin
          errors++; $display("FAIL full_ready_reopen got=0 exp=1");
        end
      end
    end
    tick();
    checks++; if (d2_valid !== 2'b00) begin
      errors++; $display("FAIL full_ninth_dropped got=%b exp=00", d2_valid);
    end
    emit_en2 = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    emit_en2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      set_rec(32'h4000 + 32'(4 * i), 32'h13, (i == 3));
      tick();
    end
    checks++; if (in_ready2 !== 1'b0) begin
      errors++; $display("FAIL halt_ready got=1 exp=0");
    end
    set_rec(32'h4FF0, 32'h13, 1'b0);
    tick();
    in_valid2 = 1'b0;
    emit_en2 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      $display("halt drain %0d: valid=%b order=%0d,%0d halt=%b", c, d2_valid,
               d2_order[63:0], d2_order[127:64], d2_halt);
      checks++; if (d2_valid !== 2'b11 || d2_order[63:0] !== 64'(2 * c)
                    || d2_order[127:64] !== 64'(2 * c + 1)
                    || d2_halt !== ((c == 1) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL halt_drain_%0d got=%b %0d,%0d halt=%b", c, d2_valid,
                           d2_order[63:0], d2_order[127:64], d2_halt);
      end
    end
    tick();
    checks++; if (d2_valid !== 2'b00 || in_ready2 !== 1'b0) begin
      errors++; $display("FAIL halt_after got valid=%b ready=%b exp=00 0", d2_valid, in_ready2);
    end
    emit_en2 = 1'b0;
  endtask

  task automatic test_order_wrap();
    do_reset();
    force dut2.ord_base_reg = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut2.ord_base_reg;
    emit_en2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1;
      set_rec(32'h5000 + 32'(4 * i), 32'h13, 1'b0);
      tick();
    end
    in_valid2 = 1'b0;
    emit_en2 = 1'b1;
    tick();
    $display("wrap 0: valid=%b order=%h,%h", d2_valid, d2_order[63:0], d2_order[127:64]);
    checks++; if (d2_valid !== 2'b11 || d2_order[63:0] !== 64'hFFFF_FFFF_FFFF_FFFE
                  || d2_order[127:64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL wrap_top got=%b %h,%h", d2_valid, d2_order[63:0], d2_order[127:64]);
    end
    tick();
    $display("wrap 1: valid=%b order=%h pc=%h", d2_valid, d2_order[63:0], d2_pc_rdata[31:0]);
    checks++; if (d2_valid !== 2'b01 || d2_order[63:0] !== 64'd0 || d2_pc_rdata[31:0] !== 32'h5008) begin
      errors++; $display("FAIL wrap_zero got=%b %h %h exp=01 0 5008",
                         d2_valid, d2_order[63:0], d2_pc_rdata[31:0]);
    end
    emit_en2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    emit_en2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      set_rec(32'h6000 + 32'(4 * i), 32'h13, 1'b0);
      tick();
    end
    in_valid2 = 1'b0;
    resetn = 1'b0;
    tick();
    checks++; if (in_ready2 !== 1'b0 || d2_valid !== 2'b00) begin
      errors++; $display("FAIL midreset_hold got ready=%b valid=%b exp=0 00", in_ready2, d2_valid);
    end
    resetn = 1'b1;
    emit_en2 = 1'b1;
    tick();
    $display("midreset: valid=%b ready=%b", d2_valid, in_ready2);
    checks++; if (d2_valid !== 2'b00 || in_ready2 !== 1'b1) begin
      errors++; $display("FAIL midreset_empty got valid=%b ready=%b exp=00 1", d2_valid, in_ready2);
    end
    in_valid2 = 1'b1;
    set_rec(32'h7000, 32'h13, 1'b0);
    tick();
    in_valid2 = 1'b0;
    tick();
    $display("midreset push: valid=%b order=%0d pc=%h", d2_valid, d2_order[63:0], d2_pc_rdata[31:0]);
    checks++; if (d2_valid !== 2'b01 || d2_order[63:0] !== 64'd0 || d2_pc_rdata[31:0] !== 32'h7000) begin
      errors++; $display("FAIL midreset_first got=%b %0d %h exp=01 0 7000",
                         d2_valid, d2_order[63:0], d2_pc_rdata[31:0]);
    end
    emit_en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_dual_channel();
    test_full();
    test_halt();
    test_order_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
